// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the i281 data-memory arbiter.
// Consumed by dmem_arb_if, dmem_rr_pick and dmem_arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 4;
    localparam int DMEM_DATA_W = 8;
    localparam int STAT_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Encoding doubles as the bit index into the eligible/mask vectors.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } gnt_e;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two requesters, the data memory and dmem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);

    logic              run;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              dmem_capture;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  run, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_ack, dmem_capture, ld_ack, ld_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output run, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_ack, dmem_capture, ld_ack, ld_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester that
// was not granted last wins; masked requesters are never picked.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  gnt_e       last_i,
    input  logic [1:0] mask_i,
    output gnt_e       gnt_o,
    output logic       vld_o
);

    logic [1:0] cand;

    always_comb begin
        cand  = elig_i & ~mask_i;
        vld_o = |cand;
        gnt_o = GNT_CPU;
        if (cand == 2'b11) begin
            gnt_o = (last_i == GNT_CPU) ? GNT_LD : GNT_CPU;
        end else if (cand[GNT_LD]) begin
            gnt_o = GNT_LD;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// SETUP/ACCESS sequencer and CPU/loader round-robin arbiter for the i281
// 16x8 data memory. Define DMEM_ARB_STATS_EN to add saturating ack counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    dmem_arb_if.slave         bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cpu_count,
    output logic [STAT_W-1:0] ld_count
`endif
);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

    logic [1:0]        elig;
    logic [1:0]        mask;
    gnt_e              pick_gnt;
    logic              pick_vld;
    logic              in_access;

    assign in_access = (state_q == ACCESS);
    assign elig      = {bus.ld_req, bus.cpu_req & bus.run};
    // At the ACCESS exit the current grantee is masked so the other side gets a turn.
    assign mask      = in_access ? {gnt_q == GNT_LD, gnt_q == GNT_CPU} : 2'b00;

    dmem_rr_pick u_pick (
        .elig_i (elig),
        .last_i (last_q),
        .mask_i (mask),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ld_rdata_d = ld_rdata_q;

        if (in_access && (gnt_q == GNT_LD) && !we_q) begin
            ld_rdata_d = bus.mem_rdata;
        end

        unique case (state_q)
            IDLE, ACCESS: begin
                if (pick_vld) begin
                    state_d = SETUP;
                    gnt_d   = pick_gnt;
                    last_d  = pick_gnt;
                    if (pick_gnt == GNT_LD) begin
                        we_d    = bus.ld_we;
                        addr_d  = bus.ld_addr;
                        wdata_d = bus.ld_wdata;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:   state_d = ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_CPU;
            last_q     <= GNT_LD;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign bus.mem_we       = in_access && we_q;
    assign bus.cpu_ack      = in_access && (gnt_q == GNT_CPU);
    assign bus.ld_ack       = in_access && (gnt_q == GNT_LD);
    assign bus.dmem_capture = in_access && (gnt_q == GNT_CPU) && !we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.ld_rdata     = ld_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] cpu_cnt_q, cpu_cnt_d;
    logic [STAT_W-1:0] ld_cnt_q, ld_cnt_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        if (bus.cpu_ack) cpu_cnt_d = sat_inc(cpu_cnt_q);
        if (bus.ld_ack)  ld_cnt_d  = sat_inc(ld_cnt_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_cnt_q <= '0;
            ld_cnt_q  <= '0;
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
        end
    end

    assign cpu_count = cpu_cnt_q;
    assign ld_count  = ld_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, scoreboarded bench for dmem_arbiter with a behavioural 16x8 memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct packed {
        logic       ld;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    int         errors = 0;
    int         checks = 0;
    exp_t       sbq[$];
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_ld_rdata;

    dmem_arb_if bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [7:0] cpu_count;
    logic [7:0] ld_count;
`endif

    dmem_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_count (cpu_count),
        .ld_count  (ld_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit ld, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (ld) begin
            bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    task automatic drop(input bit ld);
        if (ld) bus.ld_req = 1'b0;
        else    bus.cpu_req = 1'b0;
    endtask

    task automatic push(input bit ld, input bit we, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.ld = ld; e.we = we; e.addr = a;
        if (we) ref_mem[a] = d;
        e.data = we ? d : ref_mem[a];
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input bit ld, input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if ((ld ? bus.ld_ack : bus.cpu_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_ack(input bit ld, input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, sbq.size() != 0, 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk({tag, "_side"}, ld, e.ld);
        chk({tag, "_mem_we"}, bus.mem_we, e.we);
        chk({tag, "_mem_addr"}, bus.mem_addr, e.addr);
        if (e.we) chk({tag, "_mem_wdata"}, bus.mem_wdata, e.data);
        else      chk({tag, "_mem_rdata"}, bus.mem_rdata, e.data);
        chk({tag, "_capture"}, bus.dmem_capture, (!e.ld && !e.we));
        chk({tag, "_other_ack"}, ld ? bus.cpu_ack : bus.ld_ack, 0);
        if (e.ld && !e.we) exp_ld_rdata = e.data;
    endtask

    // Single access from IDLE; inputs are scrambled after grant to prove they are latched.
    task automatic run_one(input bit ld, input bit we, input logic [3:0] a, input logic [7:0] d,
                           input string tag);
        int lat;
        push(ld, we, a, d);
        drive(ld, we, a, d);
        step();
        chk({tag, "_setup_state"}, dut.state_q, SETUP);
        chk({tag, "_setup_we"}, bus.mem_we, 0);
        drive(ld, ~we, ~a, ~d);
        wait_ack(ld, 5, lat);
        chk({tag, "_latency"}, lat, 1);
        if (lat > 0) check_ack(ld, tag);
        else void'(sbq.pop_front());
        drop(ld);
        step();
        chk({tag, "_idle_after"}, dut.state_q, IDLE);
        chk({tag, "_we_after"}, bus.mem_we, 0);
        if (ld && !we) chk({tag, "_ld_rdata"}, bus.ld_rdata, exp_ld_rdata);
    endtask

    // Both sides request together; first wins, second follows with no IDLE gap.
    task automatic run_pair(input bit first_ld, input string tag);
        int lat;
        if (first_ld) begin
            push(1, 1, 4'hA, 8'h33); push(0, 0, 4'h9, 8'h00);
            drive(1, 1, 4'hA, 8'h33); drive(0, 0, 4'h9, 8'h00);
        end else begin
            push(0, 1, 4'h8, 8'h11); push(1, 1, 4'h9, 8'h22);
            drive(0, 1, 4'h8, 8'h11); drive(1, 1, 4'h9, 8'h22);
        end
        step();
        wait_ack(first_ld, 4, lat);
        chk({tag, "_first_lat"}, lat, 1);
        if (lat > 0) check_ack(first_ld, {tag, "_first"});
        else void'(sbq.pop_front());
        drop(first_ld);
        step();
        chk({tag, "_gap_state"}, dut.state_q, SETUP);
        chk({tag, "_gap_acks"}, {bus.cpu_ack, bus.ld_ack}, 2'b00);
        step();
        chk({tag, "_second_ack"}, first_ld ? bus.cpu_ack : bus.ld_ack, 1);
        check_ack(!first_ld, {tag, "_second"});
        drop(!first_ld);
        step();
        chk({tag, "_idle_after"}, dut.state_q, IDLE);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, dut.state_q, IDLE);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_acks"}, {bus.cpu_ack, bus.ld_ack, bus.dmem_capture}, 3'b000);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_ld_rdata"}, bus.ld_rdata, 0);
`ifdef DMEM_ARB_STATS_EN
        chk({tag, "_counts"}, {cpu_count, ld_count}, 16'h0000);
`endif
    endtask

    initial begin
        int lat;
        int bad;
        reset_n = 1'b0;
        bus.run = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req = 1'b0;  bus.ld_we = 1'b0;  bus.ld_addr = '0;  bus.ld_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        exp_ld_rdata = 8'h00;

        // Reset values
        repeat (3) step();
        chk_quiet("rst_hold");
        reset_n = 1'b1;
        step();
        chk_quiet("rst_release");

        // Simultaneous requests straight after reset: CPU first
        bus.run = 1'b1;
        run_pair(1'b0, "pair_cpu_first");

        // CPU write then read of address 3
        run_one(0, 1, 4'h3, 8'hA5, "cpu_wr");
        chk("cpu_wr_mem", mem[3], 8'hA5);
        run_one(0, 0, 4'h3, 8'h00, "cpu_rd");

        // Last grant is CPU, so the loader wins this tie
        run_pair(1'b1, "pair_ld_first");

        // run gating
        bus.run = 1'b0;
        drive(0, 0, 4'h3, 8'h00);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.cpu_ack !== 1'b0 || dut.state_q != IDLE) bad++;
        end
        chk("gate_no_grant", bad, 0);
        push(0, 0, 4'h3, 8'h00);
        bus.run = 1'b1;
        wait_ack(0, 6, lat);
        chk("gate_latency", lat, 2);
        if (lat > 0) check_ack(0, "gate");
        else void'(sbq.pop_front());
        drop(0);
        step();

        // run falling during SETUP does not abort
        push(0, 1, 4'h7, 8'h5A);
        drive(0, 1, 4'h7, 8'h5A);
        step();
        bus.run = 1'b0;
        wait_ack(0, 5, lat);
        chk("rundrop_latency", lat, 1);
        if (lat > 0) check_ack(0, "rundrop");
        else void'(sbq.pop_front());
        drop(0);
        bus.run = 1'b1;
        step();
        chk("rundrop_mem", mem[7], 8'h5A);

        // Loader write/read of 0xF, ld_rdata holds across a CPU read
        run_one(1, 1, 4'hF, 8'h3C, "ld_wr");
        run_one(1, 0, 4'hF, 8'h00, "ld_rd");
        chk("ld_rd_value", bus.ld_rdata, 8'h3C);
        run_one(0, 0, 4'h7, 8'h00, "cpu_rd7");
        chk("ld_rdata_hold", bus.ld_rdata, 8'h3C);

        // Reset asserted during the ACCESS of a write
        drive(0, 1, 4'h5, 8'h77);
        step();
        step();
        chk("midrst_pre_we", bus.mem_we, 1);
        chk("midrst_pre_ack", bus.cpu_ack, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_we_drop", bus.mem_we, 0);
        chk("midrst_ack_drop", bus.cpu_ack, 0);
        drop(0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        exp_ld_rdata = 8'h00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.cpu_ack !== 1'b0 || bus.ld_ack !== 1'b0) bad++;
        end
        chk("midrst_no_ack", bad, 0);
        chk_quiet("midrst_after");
        chk("midrst_mem5", mem[5], 8'h00);

`ifdef DMEM_ARB_STATS_EN
        for (int i = 0; i < 300; i++) run_one(0, 0, 4'(i), 8'h00, "stats");
        chk("stats_cpu_count", cpu_count, 8'd255);
        chk("stats_ld_count", ld_count, 8'd0);
`endif

        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and two-way arbiter for the 16 x 8-bit data memory in the multicycle i281 CPU. Shares the memory between the CPU control path and the external loader/debug port, drives address, write data and write enable, and generates the read-capture strobe for the data memory register. Every access runs as a fixed SETUP/ACCESS sequence. Simultaneous requests are resolved round-robin.

## Interface
- ADDR_W, 4, data memory address width
- DATA_W, 8, data word width
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  CPU enable; CPU requests are eligible only while high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU request is a write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- dmem_capture  out  1  read-capture strobe to the data memory register (CPU reads only)
- ld_req  in  1  loader request, held until ld_ack
- ld_we  in  1  loader request is a write
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  DATA_W  registered loader read data
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_we  out  1  memory write enable; memory writes on the rising edge
- mem_rdata  in  DATA_W  memory combinational read data

## Operation
- States:
  - IDLE: arbitrates.
  - SETUP: address and data are stable; mem_we is 0.
  - ACCESS: mem_we is asserted for writes; the read is captured; ack is pulsed.
- Eligible requests:
  - CPU: cpu_req && run.
  - Loader: ld_req.
- Arbitration in IDLE:
  - One eligible requester: it is granted.
  - Both eligible: the one not granted last (last_grant) wins.
- On grant, latch addr, wdata, we and grantee; update last_grant; go to SETUP.
- SETUP always goes to ACCESS.
- In ACCESS:
  - mem_we = latched we.
  - The grantee's ack is high.
  - CPU read: dmem_capture is high.
  - Loader read: ld_rdata <= mem_rdata.
- Leaving ACCESS:
  - The current grantee's req is masked for this decision.
  - If the other requester is eligible, go directly to SETUP with it granted.
  - Otherwise go to IDLE.
- A run falling during SETUP or ACCESS does not abort the access; it completes and is acked.
- Reset values: state IDLE, last_grant = loader (the CPU wins the first tie), all outputs 0.
- When reset_n is asserted mid-access, mem_we, acks and dmem_capture drop asynchronously. The access is lost and is not acked.
- Addresses wrap naturally within ADDR_W. No range checking.

## Timing
- Request high in IDLE at cycle N gives SETUP at N+1 and ACCESS/ack at N+2.
- The requester may drop req from N+3.
- For a write, memory contents change at the end of cycle N+2.
- Back-to-back alternating requesters: one access per 2 cycles.
- The same requester repeating goes through IDLE: one access per 3 cycles.
- ld_rdata is valid from N+3 and holds until the next loader read.
- Request inputs are sampled only in IDLE and at the ACCESS exit. Changing we/addr/wdata after grant has no effect.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds outputs cpu_count and ld_count, each 8 bits.
  - Each counter increments on its requester's ack and saturates at 255.
  - Counters reset to 0 on reset_n.
- Undefined: no counters and no count ports. All other behaviour is identical.

## Structure
- Shared package dmem_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - grantee encoding (GNT_CPU, GNT_LD)
  - default ADDR_W/DATA_W constants
- One natural sub-module: dmem_rr_pick, a combinational two-way round-robin picker taking the eligible vector, last_grant and a mask, and returning a grant and a valid signal.

## Test plan
- Reset values: hold reset_n low, then release. All outputs are 0 and the state is IDLE. Assert reset_n low during ACCESS of a write: mem_we falls immediately and no ack is produced.
- CPU write then read: run=1, CPU write addr 4'h3, data 8'hA5 -> mem_we high only in the cycle 2 after req, cpu_ack in the same cycle. A CPU read of 4'h3 then gives dmem_capture in its ACCESS cycle with mem_rdata = 8'hA5.
- Simultaneous requests after reset: CPU and loader both request -> CPU is served first, loader follows directly with no IDLE. Acks land 2 cycles apart.
- run gating: run=0 with only cpu_req high -> no grant for 10 cycles. Raise run -> ack 2 cycles later. Drop run during SETUP -> the access still completes.
- Loader read: ld write 4'hF with 8'h3C, then ld read 4'hF -> ld_rdata = 8'h3C from the cycle after ld_ack. dmem_capture stays 0 throughout.
- With DMEM_ARB_STATS_EN: 300 CPU accesses -> cpu_count = 255 and ld_count = 0.
